// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   MULT_N  : default operand width
//   state_e : FSM encoding (2'd3 is illegal and recovers to IDLE)
package shift_add_multiplier_pkg;

  localparam int unsigned MULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// N-bit ripple-carry adder used as the multiplier's accumulate datapath.
// Ports:
//   a, b      : N-bit addends
//   carry_in  : carry into bit 0
//   sum       : N-bit sum
//   carry_out : carry out of bit N-1
module AdderRCA #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  // Carry ripples through one full adder per bit.
  always_comb begin
    logic carry;
    carry = carry_in;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    carry_out = carry;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N shift-and-add multiplier, one multiplier bit per clock.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b                 : multiplicand / multiplier, sampled at acceptance
//   out_valid / out_ready: result handshake (valid only in DONE)
//   product              : 2N-bit result, zero outside DONE
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned N = MULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q;
  logic [N-1:0]     m_q;
  logic [N-1:0]     p_q;
  logic [N-1:0]     q_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [2*N-1:0]   product_q;

  logic [N-1:0]     addend_c;
  logic [N-1:0]     sum_c;
  logic             carry_c;
  logic [N-1:0]     p_d;
  logic [N-1:0]     q_d;

  // Multiplicand is gated to zero when the current multiplier bit is clear.
  assign addend_c = q_q[0] ? m_q : '0;

  AdderRCA #(.N(N)) u_adder (
    .a         (p_q),
    .b         (addend_c),
    .carry_in  (1'b0),
    .sum       (sum_c),
    .carry_out (carry_c)
  );

  // {carry, sum, Q} shifted right by one; the carry lands in P's MSB.
  assign p_d = {carry_c, sum_c[N-1:1]};
  assign q_d = {sum_c[0], q_q[N-1:1]};

  // Control FSM, counter and shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      p_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            m_q        <= a;
            p_q        <= '0;
            q_q        <= b;
            cnt_q      <= CW'(N - 1);
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          p_q <= p_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            // Final iteration: publish the freshly shifted product directly.
            product_q   <= {p_d, q_d};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          product_q   <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
